dmem_copy_master: RTL and testbench
===================================

Name: dmem_copy_master

Overview:
- Memory-side initiator for the single-cycle data memory bank. Drives memread/memwrite/address/writedata and consumes readdata.
- Copies a block of `length` 32-bit words from `src_addr` to `dst_addr` on a single `start` pulse, then signals completion with `done`.
- Used by the bench and control logic to preload or relocate data memory without going through the datapath.

Parameters:
- AW, 8, address width; matches the memory address bus.
- DW, 32, data word width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  AW  first source word address; latched on accepted start
- dst_addr  in  AW  first destination word address; latched on accepted start
- length  in  AW  word count, 0..255; latched on accepted start
- busy  out  1  high in READ and WRITE states
- done  out  1  one-cycle completion pulse
- memread  out  1  read strobe to data memory
- memwrite  out  1  write strobe to data memory
- address  out  AW  word address to data memory
- writedata  out  DW  write data to data memory
- readdata  in  DW  read data from data memory; combinational, valid in the same cycle as memread/address

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- FSM states: IDLE, READ, WRITE, DONE. All outputs decode from registered state and registered counters, so there is no input-to-output combinational path.
- On reset, at the next clk edge:
  - state = IDLE.
  - Counters, latched addresses and the data register clear to 0.
  - busy = done = memread = memwrite = 0; address = 0; writedata = 0.
- IDLE:
  - With start=1, latch src/dst/length and set idx = 0.
  - Go to READ if length != 0, otherwise go to DONE.
  - With start=0, stay in IDLE.
- READ:
  - Drive memread=1, memwrite=0, address = src_q + idx (mod 2^AW).
  - At the clk edge, capture readdata into data_q and go to WRITE.
- WRITE:
  - Drive memwrite=1, memread=0, address = dst_q + idx (mod 2^AW), writedata = data_q.
  - At the edge: if idx == len_q-1, go to DONE; otherwise idx++ and go to READ.
- DONE: done=1 for exactly one cycle, busy=0, no strobes. Go to IDLE on the next edge.
- memread and memwrite are never high in the same cycle. Outside READ and WRITE, address holds 0 and writedata holds 0.
- Timing, with cycle 0 being the cycle start is sampled:
  - Word k is read in cycle 2k+1 and written in cycle 2k+2.
  - done is high in cycle 2L+1.
  - length=0 gives done in cycle 1 with no memory access.
- Address arithmetic wraps modulo 2^AW. No range check against the memory depth.
- Copy is strictly ascending by word.
  - Overlapping ranges with dst > src propagate already-copied words. This is defined behaviour, not an error.
- start asserted in READ, WRITE or DONE is ignored and not queued.
- start asserted in the cycle after done (IDLE) is accepted normally.
- Input changes on src_addr, dst_addr or length after acceptance have no effect.
- Reset mid-copy: at the next edge, return to IDLE with all strobes low and no done pulse. Words already written stay written.

Optional Feature:
- Macro: DMEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output port `checksum` (DW).
  - The register clears on accepted start and on reset.
  - In each WRITE cycle, adds data_q to the register modulo 2^DW.
  - The final value is valid while done=1 and is held until the next accepted start.
- Undefined: no checksum port and no accumulator logic.

Test Plan:
- Preload mem[0..9] = 7,5,8,3,4,10,6,1,2,0. Copy with src=0, dst=20, length=4.
  - mem[20..23] = 7,5,8,3.
  - done in cycle 9; busy high in cycles 1..8.
  - checksum = 23 when enabled.
- length=0, src=3, dst=40 -> done in cycle 1, memread and memwrite never asserted, mem[40] unchanged.
- Overlap: src=0, dst=1, length=3 on the preload -> mem[1..3] = 7,7,7.
- start pulses in cycles 2 and 4 during a length=2 copy -> both ignored; exactly one done, in cycle 5.
- Wrap: src=254, dst=10, length=4 -> reads addresses 254, 255, 0, 1 in order; writes addresses 10..13.
- reset asserted in cycle 3 of a length=4 copy src=0, dst=30:
  - mem[30] = 7 and mem[31] stays unwritten.
  - IDLE after that edge; no done pulse.
  - A following copy works normally.

Source files
------------

// File: rtl/dmem_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : dmem_copy_master
// Purpose  : Memory-side initiator that copies a block of DW-bit words from
//            src_addr to dst_addr in the single-cycle data memory.
//            Each word takes one READ cycle followed by one WRITE cycle.
//            A one-cycle done pulse marks completion.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            start             - copy request, accepted only in IDLE
//            src_addr/dst_addr - first source/destination word address
//            length            - number of words (0 gives an immediate done)
//            busy, done        - status outputs
//            memread/memwrite/address/writedata/readdata - memory port
//            checksum          - sum of copied words (DMEM_COPY_CHECKSUM_EN)
// Options  : `define DMEM_COPY_CHECKSUM_EN adds the checksum accumulator/port
// Revision : 1.0 - initial release
// ============================================================================
module dmem_copy_master #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          memread,
  output logic          memwrite,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  input  logic [DW-1:0] readdata
`ifdef DMEM_COPY_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  localparam logic [AW-1:0] c_one = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DW-1:0] cs_q, cs_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
      cs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef DMEM_COPY_CHECKSUM_EN
      cs_q    <= cs_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef DMEM_COPY_CHECKSUM_EN
    cs_d    = cs_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          idx_d   = '0;
`ifdef DMEM_COPY_CHECKSUM_EN
          cs_d    = '0;
`endif
          state_d = (length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        data_d  = readdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef DMEM_COPY_CHECKSUM_EN
        cs_d = cs_q + data_q;
`endif
        // len_q is non-zero whenever WRITE is reached, so len_q-1 cannot wrap.
        if (idx_q == len_q - c_one) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + c_one;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state, so no input reaches an
  // output combinationally; address/writedata are zero outside transfers.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    address   = '0;
    writedata = '0;
    case (state_q)
      S_READ: begin
        busy    = 1'b1;
        memread = 1'b1;
        address = src_q + idx_q;
      end
      S_WRITE: begin
        busy      = 1'b1;
        memwrite  = 1'b1;
        address   = dst_q + idx_q;
        writedata = data_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef DMEM_COPY_CHECKSUM_EN
  assign checksum = cs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_copy_master
// Purpose  : Self-checking bench for dmem_copy_master with a behavioural
//            single-cycle data memory and an address/data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  length = '0;
  logic        busy, done, memread, memwrite;
  logic [7:0]  address;
  logic [31:0] writedata, readdata;
`ifdef DMEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  dmem_copy_master #(.AW(8), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata)
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural data memory; bench preloads share the single write port.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (memwrite) mem[address] <= writedata;
  end
  assign readdata = mem[address];

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard queues
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  exp_wa_q [$];
  logic [31:0] exp_wd_q [$];
  logic [31:0] exp_cs;
  logic [31:0] cs_at_done;
  logic [7:0]  mon_a;
  logic [31:0] mon_d;

  always @(negedge clk) begin
    if (memread === 1'b1 && memwrite === 1'b1) begin
      n_checks++;
      $display("FAIL strobe_exclusive: memread=1 memwrite=1 required not both");
    end
    if (memread === 1'b1) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        $display("FAIL sb_read: unexpected read at address %0d, none required", address);
      end else begin
        mon_a = exp_rd_q.pop_front();
        if (address !== mon_a) $display("FAIL sb_read: address %0d required %0d", address, mon_a);
        else n_pass++;
      end
    end
    if (memwrite === 1'b1) begin
      n_checks++;
      if (exp_wa_q.size() == 0) begin
        $display("FAIL sb_write: unexpected write at address %0d, none required", address);
      end else begin
        mon_a = exp_wa_q.pop_front();
        mon_d = exp_wd_q.pop_front();
        if (address !== mon_a || writedata !== mon_d)
          $display("FAIL sb_write: addr/data %0d/%0d required %0d/%0d", address, writedata, mon_a, mon_d);
        else n_pass++;
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic preload_base();
    logic [31:0] base [10] = '{7, 5, 8, 3, 4, 10, 6, 1, 2, 0};
    for (int i = 0; i < 10; i++) preload(8'(i), base[i]);
  endtask

  // Reference copy: strictly ascending, so overlapping ranges propagate.
  task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int l);
    logic [7:0]  ra, wa;
    logic [31:0] wd;
    exp_cs = '0;
    for (int k = 0; k < l; k++) begin
      ra = s + 8'(k);
      wa = d + 8'(k);
      wd = ref_mem[ra];
      ref_mem[wa] = wd;
      exp_cs = exp_cs + wd;
      exp_rd_q.push_back(ra);
      exp_wa_q.push_back(wa);
      exp_wd_q.push_back(wd);
    end
  endtask

  // Drives start in cycle 0 and observes ncyc cycles; extra start pulses and a
  // reset pulse can be placed in chosen cycles. Inputs are scrambled after
  // acceptance to confirm they were latched.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int ncyc, input int st1, input int st2, input int rst_c,
                          output int done_cyc, output int done_cnt,
                          output int busy_first, output int busy_last, output int strobes);
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; strobes = 0;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
`ifdef DMEM_COPY_CHECKSUM_EN
          cs_at_done = checksum;
`endif
        end
      end
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (memread === 1'b1 || memwrite === 1'b1) strobes++;
      @(posedge clk); #1;
      start = ((c + 1) == st1) || ((c + 1) == st2);
      reset = ((c + 1) == rst_c);
      if (c == 0) begin
        src_addr = ~s; dst_addr = ~d; length = ~l;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: %b required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: %b required 0", done); else n_pass++;
    n_checks++; if (memread !== 1'b0) $display("FAIL reset_memread: %b required 0", memread); else n_pass++;
    n_checks++; if (memwrite !== 1'b0) $display("FAIL reset_memwrite: %b required 0", memwrite); else n_pass++;
    n_checks++; if (address !== 8'd0) $display("FAIL reset_address: %0d required 0", address); else n_pass++;
    n_checks++; if (writedata !== 32'd0) $display("FAIL reset_writedata: %0d required 0", writedata); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int dc, dn, bf, bl, sc;
    logic [31:0] exp4 [4] = '{7, 5, 8, 3};
    push_copy(8'd0, 8'd20, 4);
    run_copy(8'd0, 8'd20, 8'd4, 12, -1, -1, -1, dc, dn, bf, bl, sc);
    n_checks++; if (dc !== 9) $display("FAIL basic_done_cycle: %0d required 9", dc); else n_pass++;
    n_checks++; if (dn !== 1) $display("FAIL basic_done_count: %0d required 1", dn); else n_pass++;
    n_checks++; if (bf !== 1 || bl !== 8) $display("FAIL basic_busy_window: %0d..%0d required 1..8", bf, bl); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[20+i] !== exp4[i]) $display("FAIL basic_mem[%0d]: %0d required %0d", 20+i, mem[20+i], exp4[i]);
      else n_pass++;
    end
    n_checks++; if (exp_wa_q.size() != 0) $display("FAIL basic_sb_drain: %0d left required 0", exp_wa_q.size()); else n_pass++;
`ifdef DMEM_COPY_CHECKSUM_EN
    n_checks++; if (cs_at_done !== 32'd23) $display("FAIL basic_checksum: %0d required 23", cs_at_done); else n_pass++;
    n_checks++; if (checksum !== exp_cs) $display("FAIL checksum_hold: %0d required %0d", checksum, exp_cs); else n_pass++;
`endif
  endtask

  task automatic test_len0();
    int dc, dn, bf, bl, sc;
    run_copy(8'd3, 8'd40, 8'd0, 5, -1, -1, -1, dc, dn, bf, bl, sc);
    n_checks++; if (dc !== 1 || dn !== 1) $display("FAIL len0_done: cycle %0d count %0d required cycle 1 count 1", dc, dn); else n_pass++;
    n_checks++; if (sc !== 0 || bf !== -1) $display("FAIL len0_no_access: strobes %0d busy %0d required 0 and -1", sc, bf); else n_pass++;
    n_checks++; if (mem[40] !== 32'h55) $display("FAIL len0_mem40: %0h required 55", mem[40]); else n_pass++;
  endtask

  task automatic test_overlap();
    int dc, dn, bf, bl, sc;
    push_copy(8'd0, 8'd1, 3);
    run_copy(8'd0, 8'd1, 8'd3, 10, -1, -1, -1, dc, dn, bf, bl, sc);
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (mem[i] !== 32'd7) $display("FAIL overlap_mem[%0d]: %0d required 7", i, mem[i]);
      else n_pass++;
    end
    n_checks++; if (exp_wa_q.size() != 0) $display("FAIL overlap_sb_drain: %0d left required 0", exp_wa_q.size()); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int dc, dn, bf, bl, sc;
    push_copy(8'd0, 8'd60, 2);
    run_copy(8'd0, 8'd60, 8'd2, 12, 2, 4, -1, dc, dn, bf, bl, sc);
    n_checks++; if (dn !== 1 || dc !== 5) $display("FAIL ignore_start_done: count %0d cycle %0d required 1 and 5", dn, dc); else n_pass++;
    n_checks++; if (sc !== 4) $display("FAIL ignore_start_strobes: %0d required 4", sc); else n_pass++;
    n_checks++; if (mem[60] !== 32'd7 || mem[61] !== 32'd5) $display("FAIL ignore_start_mem: %0d,%0d required 7,5", mem[60], mem[61]); else n_pass++;
  endtask

  task automatic test_wrap();
    int dc, dn, bf, bl, sc;
    logic [31:0] expw [4] = '{32'h11, 32'h22, 7, 5};
    preload(8'd254, 32'h11);
    preload(8'd255, 32'h22);
    push_copy(8'd254, 8'd10, 4);
    run_copy(8'd254, 8'd10, 8'd4, 12, -1, -1, -1, dc, dn, bf, bl, sc);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[10+i] !== expw[i]) $display("FAIL wrap_mem[%0d]: %0h required %0h", 10+i, mem[10+i], expw[i]);
      else n_pass++;
    end
    n_checks++; if (exp_rd_q.size() != 0) $display("FAIL wrap_sb_drain: %0d left required 0", exp_rd_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dc, dn, bf, bl, sc;
    exp_rd_q.push_back(8'd0);
    exp_wa_q.push_back(8'd30);
    exp_wd_q.push_back(ref_mem[0]);
    ref_mem[30] = ref_mem[0];
    exp_rd_q.push_back(8'd1);
    run_copy(8'd0, 8'd30, 8'd4, 10, -1, -1, 3, dc, dn, bf, bl, sc);
    n_checks++; if (mem[30] !== 32'd7) $display("FAIL rstmid_mem30: %0d required 7", mem[30]); else n_pass++;
    n_checks++; if (mem[31] !== 32'hDEAD) $display("FAIL rstmid_mem31: %0h required dead", mem[31]); else n_pass++;
    n_checks++; if (dn !== 0) $display("FAIL rstmid_no_done: %0d required 0", dn); else n_pass++;
    n_checks++; if (bl !== 3) $display("FAIL rstmid_idle: last busy %0d required 3", bl); else n_pass++;
    n_checks++; if (exp_rd_q.size() != 0) $display("FAIL rstmid_sb_drain: %0d left required 0", exp_rd_q.size()); else n_pass++;
  endtask

  task automatic test_after_reset();
    int dc, dn, bf, bl, sc;
    logic [31:0] expa [3] = '{4, 10, 6};
    push_copy(8'd4, 8'd50, 3);
    run_copy(8'd4, 8'd50, 8'd3, 10, -1, -1, -1, dc, dn, bf, bl, sc);
    n_checks++; if (dc !== 7 || dn !== 1) $display("FAIL after_rst_done: cycle %0d count %0d required 7 and 1", dc, dn); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem[50+i] !== expa[i]) $display("FAIL after_rst_mem[%0d]: %0d required %0d", 50+i, mem[50+i], expa[i]);
      else n_pass++;
    end
  endtask

  // Back-to-back: start in the cycle right after done is accepted.
  task automatic test_back_to_back();
    int dc, dn, bf, bl, sc;
    push_copy(8'd5, 8'd70, 1);
    run_copy(8'd5, 8'd70, 8'd1, 3, -1, -1, -1, dc, dn, bf, bl, sc);
    push_copy(8'd6, 8'd71, 1);
    run_copy(8'd6, 8'd71, 8'd1, 5, -1, -1, -1, dc, dn, bf, bl, sc);
    n_checks++; if (dc !== 3) $display("FAIL b2b_done_cycle: %0d required 3", dc); else n_pass++;
    n_checks++; if (mem[70] !== 32'd10 || mem[71] !== 32'd6) $display("FAIL b2b_mem: %0d,%0d required 10,6", mem[70], mem[71]); else n_pass++;
  endtask

  initial begin
    test_reset();
    preload_base();
    preload(8'd40, 32'h55);
    preload(8'd31, 32'hDEAD);
    test_basic();
    test_len0();
    test_overlap();
    preload(8'd1, 32'd5);
    preload(8'd2, 32'd8);
    preload(8'd3, 32'd3);
    test_start_ignored();
    test_wrap();
    test_reset_mid();
    test_after_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
